// File: rtl/rf_writeback_sequencer.sv
// Sole writer of the register file: merges 1-cycle ALU results with FIFO-buffered load results
// and keeps a per-register load-busy scoreboard. Define WB_BYPASS_EN to let loads skip an empty FIFO.
module rf_writeback_sequencer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   ld_issue,
    input  logic [4:0]             ld_rd,
    output logic                   ld_issue_ready,
    input  logic [4:0]             q_rs1,
    input  logic [4:0]             q_rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [4:0]      fifo_rd   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            accept;
    logic            alu_take;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            bypass;
    logic            issue_set;

    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign mem_ready  = !reset && (fifo_count < FULL);
    assign accept     = mem_valid && mem_ready;
    assign alu_take   = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !alu_take && !fifo_empty;

`ifdef WB_BYPASS_EN
    // An empty FIFO and an idle ALU slot let the load go straight to the write port.
    assign bypass = accept && (mem_rd != 5'd0) && fifo_empty && !alu_take;
`else
    assign bypass = 1'b0;
`endif

    // x0 loads complete the handshake but are never stored.
    assign push = accept && (mem_rd != 5'd0) && !bypass;

    assign ld_issue_ready = (ld_rd == 5'd0) || !busy[ld_rd];
    assign issue_set      = ld_issue && ld_issue_ready && (ld_rd != 5'd0);
    assign rs1_busy       = (q_rs1 != 5'd0) && busy[q_rs1];
    assign rs2_busy       = (q_rs2 != 5'd0) && busy[q_rs2];

    // Clears first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (pop)
            busy_nxt[head_rd] = 1'b0;
        if (bypass)
            busy_nxt[mem_rd] = 1'b0;
        if (issue_set)
            busy_nxt[ld_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            busy       <= '0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
            busy <= busy_nxt;

            if (alu_take) begin
                wb_we   <= 1'b1;
                wb_rd   <= alu_rd;
                wb_data <= alu_data;
            end else if (pop) begin
                wb_we   <= 1'b1;
                wb_rd   <= head_rd;
                wb_data <= head_data;
            end else if (bypass) begin
                wb_we   <= 1'b1;
                wb_rd   <= mem_rd;
                wb_data <= mem_data;
            end else begin
                wb_we <= 1'b0;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_rd[wr_ptr]   <= mem_rd;
        end
    end
endmodule

// File: tb/tb_rf_writeback_sequencer.sv
// Bench for rf_writeback_sequencer: directed scenarios plus randomized traffic checked
// against a queue-based model of the write-back rules.
module tb_rf_writeback_sequencer;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            ld_issue;
    logic [4:0]      ld_rd;
    logic            ld_issue_ready;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [CW-1:0]   fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rf_writeback_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_issue_ready(ld_issue_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fifo_count(fifo_count)
    );

    // Reference model: pending loads as a queue, busy as a bit per register.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    bit              mbusy[32];
    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;

    function automatic bit m_ready();
        return !reset && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_issue_ready();
        return (ld_rd == 5'd0) || !mbusy[ld_rd];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && mbusy[r];
    endfunction

    task automatic model_step();
        bit   acc;
        bit   set_b;
        ent_t e;
        if (reset) begin
            exp_we   = 1'b0;
            exp_rd   = 5'd0;
            exp_data = '0;
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
        end else begin
            acc   = mem_valid && m_ready() && (mem_rd != 5'd0);
            set_b = ld_issue && m_issue_ready() && (ld_rd != 5'd0);
            exp_we = 1'b0;
            if (alu_valid && alu_rd != 5'd0) begin
                exp_we = 1'b1; exp_rd = alu_rd; exp_data = alu_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_we = 1'b1; exp_rd = e.rd; exp_data = e.data;
                mbusy[e.rd] = 1'b0;
            end
`ifdef WB_BYPASS_EN
            else if (acc) begin
                exp_we = 1'b1; exp_rd = mem_rd; exp_data = mem_data;
                mbusy[mem_rd] = 1'b0;
                acc = 1'b0;
            end
`endif
            if (acc) begin
                e.rd = mem_rd; e.data = mem_data;
                mq.push_back(e);
            end
            if (set_b) mbusy[ld_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
        ld_issue = 1'b0; ld_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = '1;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = '1;
        ld_issue = 1'b1; ld_rd = 5'd5; q_rs1 = 5'd5; q_rs2 = 5'd4;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (mem_ready !== 1'b0) begin
                tests_failed++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready);
            end
            tick();
            tests_run++;
            if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== '0 || fifo_count !== '0) begin
                tests_failed++;
                $display("FAIL reset_state: we=%b rd=%0d data=%h count=%0d expected all zero",
                         wb_we, wb_rd, wb_data, fifo_count);
            end
        end
        drive_idle();
        reset = 1'b0;
        for (int r = 1; r < 32; r++) begin
            q_rs1 = 5'(r); q_rs2 = 5'(31 - r + 1);
            #1;
            tests_run++;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                tests_failed++; $display("FAIL reset_busy r=%0d: got %b%b expected 00", r, rs1_busy, rs2_busy);
            end
        end
        tests_run++;
        if (mem_ready !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset_ready: got %b expected 1", mem_ready);
        end
    endtask

    task automatic test_alu_write();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        tests_run++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h1234) begin
            tests_failed++;
            $display("FAIL alu_write: we=%b rd=%0d data=%h expected 1 5 1234", wb_we, wb_rd, wb_data);
        end
        alu_rd = 5'd0; alu_data = 64'hdead;
        tick();
        tests_run++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 64'h1234) begin
            tests_failed++;
            $display("FAIL alu_x0_drop: we=%b rd=%0d data=%h expected 0 5 1234", wb_we, wb_rd, wb_data);
        end
        drive_idle();
    endtask

    task automatic test_load_flow();
        int lat;
        drive_idle();
        ld_issue = 1'b1; ld_rd = 5'd7; q_rs1 = 5'd7;
        #1;
        tests_run++;
        if (ld_issue_ready !== 1'b1 || rs1_busy !== 1'b0) begin
            tests_failed++; $display("FAIL load_pre_issue: ready=%b busy=%b expected 1 0", ld_issue_ready, rs1_busy);
        end
        tick();
        ld_issue = 1'b0;
        #1;
        tests_run++;
        if (ld_issue_ready !== 1'b0 || rs1_busy !== 1'b1) begin
            tests_failed++; $display("FAIL load_busy_set: ready=%b busy=%b expected 0 1", ld_issue_ready, rs1_busy);
        end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'hAA;
        #1;
        tests_run++;
        if (mem_ready !== 1'b1) begin
            tests_failed++; $display("FAIL load_mem_ready: got %b expected 1", mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        lat = 1;
        while (wb_we !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat !== EXP_LAT) begin
            tests_failed++; $display("FAIL load_latency: got %0d cycles expected %0d", lat, EXP_LAT);
        end
        tests_run++;
        if (wb_rd !== 5'd7 || wb_data !== 64'hAA || rs1_busy !== 1'b0 || ld_issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_write: rd=%0d data=%h busy=%b ready=%b expected 7 aa 0 1",
                     wb_rd, wb_data, rs1_busy, ld_issue_ready);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_priority_backpressure();
        int  nxt;
        bit  acc;
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd1;
        nxt = 2;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h102;
        for (int c = 0; c < 8; c++) begin
            alu_data = {32'h0, $urandom};
            #1;
            acc = mem_valid && mem_ready;
            tick();
            tests_run++;
            if (wb_we !== 1'b1 || wb_rd !== 5'd1 || wb_data !== alu_data) begin
                tests_failed++;
                $display("FAIL prio_alu c=%0d: we=%b rd=%0d data=%h expected 1 1 %h", c, wb_we, wb_rd, wb_data, alu_data);
            end
            if (acc) begin
                nxt++;
                mem_rd = 5'(nxt); mem_data = 64'h100 + 64'(nxt);
            end
        end
        #1;
        tests_run++;
        if (fifo_count !== CW'(4) || mem_ready !== 1'b0 || nxt !== 6) begin
            tests_failed++;
            $display("FAIL prio_full: count=%0d ready=%b accepted=%0d expected 4 0 4", fifo_count, mem_ready, nxt - 2);
        end
        alu_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            acc = mem_valid && mem_ready;
            tick();
            if (acc) mem_valid = 1'b0;
            tests_run++;
            if (wb_we !== 1'b1 || wb_rd !== 5'(2 + k) || wb_data !== 64'h100 + 64'(2 + k)) begin
                tests_failed++;
                $display("FAIL prio_drain k=%0d: we=%b rd=%0d data=%h expected 1 %0d %h",
                         k, wb_we, wb_rd, wb_data, 2 + k, 64'h100 + 64'(2 + k));
            end
        end
        tick();
        tests_run++;
        if (wb_we !== 1'b0 || fifo_count !== '0) begin
            tests_failed++; $display("FAIL prio_empty: we=%b count=%0d expected 0 0", wb_we, fifo_count);
        end
        drive_idle();
    endtask

    task automatic test_wrap_around();
        logic [XLEN-1:0] dat [10];
        int sent;
        int got;
        bit acc;
        drive_idle();
        for (int i = 0; i < 10; i++) dat[i] = {$urandom, $urandom};
        sent = 0; got = 0;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = dat[0];
        alu_rd = 5'd1;
        for (int c = 0; c < 80 && got < 10; c++) begin
            alu_valid = c[0];
            alu_data = 64'(c);
            #1;
            acc = mem_valid && mem_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    mem_rd = 5'(8 + sent); mem_data = dat[sent];
                end else begin
                    mem_valid = 1'b0;
                end
            end
            if (wb_we === 1'b1 && wb_rd !== 5'd1) begin
                tests_run++;
                if (wb_rd !== 5'(8 + got) || wb_data !== dat[got]) begin
                    tests_failed++;
                    $display("FAIL wrap_order #%0d: rd=%0d data=%h expected %0d %h", got, wb_rd, wb_data, 8 + got, dat[got]);
                end
                got++;
            end
        end
        tests_run++;
        if (got !== 10) begin
            tests_failed++; $display("FAIL wrap_count: got %0d writes expected 10", got);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h55;
        ld_issue = 1'b1; ld_rd = 5'd2;
        for (int c = 0; c < 3; c++) begin
            mem_valid = 1'b1; mem_rd = 5'(2 + c); mem_data = 64'h200 + 64'(c);
            tick();
            ld_issue = 1'b0;
        end
        mem_valid = 1'b0; q_rs1 = 5'd2;
        #1;
        tests_run++;
        if (fifo_count !== CW'(3) || rs1_busy !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_pre: count=%0d busy2=%b expected 3 1", fifo_count, rs1_busy);
        end
        reset = 1'b1; mem_valid = 1'b1; mem_rd = 5'd9;
        tick();
        reset = 1'b0;
        drive_idle();
        q_rs1 = 5'd2;
        #1;
        tests_run++;
        if (fifo_count !== '0 || wb_we !== 1'b0 || rs1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_post: count=%0d we=%b busy2=%b expected 0 0 0", fifo_count, wb_we, rs1_busy);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++;
            if (wb_we !== 1'b0) begin
                tests_failed++; $display("FAIL midreset_stale c=%0d: we=%b rd=%0d expected we 0", c, wb_we, wb_rd);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            alu_valid = $urandom_range(0, 1);
            alu_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            alu_data  = {$urandom, $urandom};
            mem_valid = $urandom_range(0, 1);
            mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mem_data  = {$urandom, $urandom};
            ld_issue  = ($urandom_range(0, 4) < 2);
            ld_rd     = 5'($urandom);
            q_rs1     = 5'($urandom);
            q_rs2     = 5'($urandom);
            #1;
            tests_run++;
            if ({mem_ready, ld_issue_ready, rs1_busy, rs2_busy} !==
                {m_ready(), m_issue_ready(), m_busy(q_rs1), m_busy(q_rs2)}) begin
                tests_failed++;
                $display("FAIL rand_comb c=%0d: ready/issue/rs1/rs2=%b%b%b%b expected %b%b%b%b", c,
                         mem_ready, ld_issue_ready, rs1_busy, rs2_busy,
                         m_ready(), m_issue_ready(), m_busy(q_rs1), m_busy(q_rs2));
            end
            tick();
            tests_run++;
            if ({wb_we, wb_rd, wb_data, fifo_count} !== {exp_we, exp_rd, exp_data, CW'(mq.size())}) begin
                tests_failed++;
                $display("FAIL rand_wb c=%0d: we=%b rd=%0d data=%h count=%0d expected %b %0d %h %0d", c,
                         wb_we, wb_rd, wb_data, fifo_count, exp_we, exp_rd, exp_data, mq.size());
            end
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_alu_write();
        test_load_flow();
        test_priority_backpressure();
        test_wrap_around();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
